// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its pickers.
package uart_arb_pkg;

  // Arbiter control states: pick a requester, hand a byte to uart_tx, hold a packet grant.
  typedef enum logic [1:0] {
    ARB  = 2'd0,
    SEND = 2'd1,
    LOCK = 2'd2
  } arb_state_t;

  // A timeout of zero means a locked requester is never forced off.
  localparam int TIMEOUT_DISABLED = 0;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int id_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  // Width able to hold the value cycles without wrapping; at least one bit.
  function automatic int timer_width(input int cycles);
    if (cycles <= 0) return 1;
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request scanning cyclically from ptr.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  // Scan from farthest to nearest so the request closest to ptr is written last and wins.
  always_comb begin
    winner = '0;
    any    = |req;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (req[idx]) winner = ID_W'(idx);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking in front of a single uart_tx.
// A grant is held from the first byte of a packet until its last byte, until
// the holder is masked off, or until it idles for TIMEOUT_CYCLES clocks.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ          = 4,
  parameter  int DATA_WIDTH     = 8,
  parameter  int TIMEOUT_CYCLES = 1_000_000,
  localparam int ID_W           = id_width(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ-1:0]            req_mask,
  output logic [N_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]       tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [ID_W-1:0]             grant_id,
  output logic                        locked,
  output logic                        timeout_pulse
);

  localparam int              TMR_W    = timer_width(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);

  arb_state_t            state_reg, state_next;
  logic [ID_W-1:0]       ptr_reg, ptr_next;
  logic [DATA_WIDTH-1:0] tx_data_reg, tx_data_next;
  logic                  tx_valid_reg, tx_valid_next;
  logic [ID_W-1:0]       grant_id_reg, grant_id_next;
  logic                  locked_reg, locked_next;
  logic                  timeout_pulse_reg, timeout_pulse_next;
  logic [TMR_W-1:0]      timer_reg, timer_next;

  logic [N_REQ-1:0]      candidates;
  logic [ID_W-1:0]       pick;
  logic                  pick_any;
  logic [ID_W-1:0]       sel_id;
  logic                  accept;
  logic [ID_W-1:0]       ptr_after_grant;

  assign candidates = req_valid & req_mask;

  uart_rr_picker #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .req    (candidates),
    .ptr    (ptr_reg),
    .winner (pick),
    .any    (pick_any)
  );

  // In LOCK only the holder may send; otherwise the picker's choice is used.
  assign sel_id = (state_reg == LOCK) ? grant_id_reg : pick;

  // Pointer moves one past the requester that just gave up the transmitter.
  assign ptr_after_grant = (grant_id_reg == ID_W'(N_REQ - 1)) ? '0 : grant_id_reg + 1'b1;

  // Next-state logic: capture, hand-off to uart_tx, and lock release decisions.
  always_comb begin
    state_next         = state_reg;
    ptr_next           = ptr_reg;
    tx_data_next       = tx_data_reg;
    tx_valid_next      = tx_valid_reg;
    grant_id_next      = grant_id_reg;
    locked_next        = locked_reg;
    timeout_pulse_next = 1'b0;
    timer_next         = timer_reg;
    accept             = 1'b0;

    case (state_reg)
      ARB: begin
        accept = pick_any;
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_next = 1'b0;
          if (locked_reg) begin
            state_next = LOCK;
            timer_next = TMR_LOAD;
          end else begin
            state_next = ARB;
            ptr_next   = ptr_after_grant;
          end
        end
      end
      LOCK: begin
        if (req_valid[grant_id_reg] && req_mask[grant_id_reg]) begin
          accept = 1'b1;
        end else if (!req_mask[grant_id_reg]) begin
          // Holder was made ineligible: drop the lock quietly.
          locked_next = 1'b0;
          ptr_next    = ptr_after_grant;
          state_next  = ARB;
        end else if ((TIMEOUT_CYCLES != TIMEOUT_DISABLED) && (timer_reg == TMR_W'(1))) begin
          timeout_pulse_next = 1'b1;
          locked_next        = 1'b0;
          ptr_next           = ptr_after_grant;
          state_next         = ARB;
        end else if (timer_reg != '0) begin
          timer_next = timer_reg - 1'b1;
        end
      end
      default: begin
        state_next = ARB;
      end
    endcase

    if (accept) begin
      tx_data_next  = req_data[int'(sel_id)*DATA_WIDTH +: DATA_WIDTH];
      tx_valid_next = 1'b1;
      grant_id_next = sel_id;
      locked_next   = ~req_last[sel_id];
      state_next    = SEND;
    end
  end

  // One-hot ready toward the requester whose byte is captured this cycle.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (sel_id == ID_W'(gi));
    end
  endgenerate

  // State registers; reset clears everything so a byte in flight is discarded.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg         <= ARB;
      ptr_reg           <= '0;
      tx_data_reg       <= '0;
      tx_valid_reg      <= 1'b0;
      grant_id_reg      <= '0;
      locked_reg        <= 1'b0;
      timeout_pulse_reg <= 1'b0;
      timer_reg         <= '0;
    end else begin
      state_reg         <= state_next;
      ptr_reg           <= ptr_next;
      tx_data_reg       <= tx_data_next;
      tx_valid_reg      <= tx_valid_next;
      grant_id_reg      <= grant_id_next;
      locked_reg        <= locked_next;
      timeout_pulse_reg <= timeout_pulse_next;
      timer_reg         <= timer_next;
    end
  end

  assign tx_data       = tx_data_reg;
  assign tx_valid      = tx_valid_reg;
  assign grant_id      = grant_id_reg;
  assign locked        = locked_reg;
  assign timeout_pulse = timeout_pulse_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of single-byte grants plus
// hand-written packet-lock, timeout, mask-release and reset sequences.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [3:0]  req_mask;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        locked;
  logic        timeout_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] DATA_DEF = 32'hD3C2_B1A0;

  uart_tx_arbiter #(
    .N_REQ          (4),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_mask      (req_mask),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .grant_id      (grant_id),
    .locked        (locked),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        cap;
    logic [7:0]  txd;
    logic [1:0]  gid;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // uart_tx accepts the held byte on the next edge.
  task automatic xfer();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // valid, mask, data, ready, cap, txd, gid
    vecs[0] = '{4'b0100, 4'b1111, 32'hD35A_B1A0, 4'b0100, 1'b1, 8'h5A, 2'd2};
    vecs[1] = '{4'b0011, 4'b1111, DATA_DEF,      4'b0001, 1'b1, 8'hA0, 2'd0};
    vecs[2] = '{4'b0011, 4'b1111, DATA_DEF,      4'b0010, 1'b1, 8'hB1, 2'd1};
    vecs[3] = '{4'b0011, 4'b1111, DATA_DEF,      4'b0001, 1'b1, 8'hA0, 2'd0};
    vecs[4] = '{4'b0011, 4'b1111, DATA_DEF,      4'b0010, 1'b1, 8'hB1, 2'd1};
    vecs[5] = '{4'b0011, 4'b1111, DATA_DEF,      4'b0001, 1'b1, 8'hA0, 2'd0};
    vecs[6] = '{4'b0011, 4'b1111, DATA_DEF,      4'b0010, 1'b1, 8'hB1, 2'd1};
    vecs[7] = '{4'b1111, 4'b0000, DATA_DEF,      4'b0000, 1'b0, 8'hB1, 2'd1};
    vecs[8] = '{4'b1011, 4'b1110, DATA_DEF,      4'b1000, 1'b1, 8'hD3, 2'd3};
    vecs[9] = '{4'b1010, 4'b1111, DATA_DEF,      4'b0010, 1'b1, 8'hB1, 2'd1};

    rst_l     = 1'b0;
    req_data  = DATA_DEF;
    req_valid = 4'b0000;
    req_last  = 4'b1111;
    req_mask  = 4'b1111;
    tx_ready  = 1'b0;
    tick();
    tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_locked", locked, 0);
    chk("rst_pulse", timeout_pulse, 0);
    @(negedge clk);
    rst_l = 1'b1;
    tick();

    // Table: single-byte packets from ARB, each carried to completion.
    for (int i = 0; i < 10; i++) begin
      req_valid = vecs[i].valid;
      req_mask  = vecs[i].mask;
      req_data  = vecs[i].data;
      req_last  = 4'b1111;
      #1;
      chk($sformatf("v%0d_ready", i), req_ready, vecs[i].ready);
      tick();
      req_valid = 4'b0000;
      req_mask  = 4'b1111;
      chk($sformatf("v%0d_tx_valid", i), tx_valid, vecs[i].cap);
      chk($sformatf("v%0d_tx_data", i), tx_data, vecs[i].txd);
      chk($sformatf("v%0d_grant", i), grant_id, vecs[i].gid);
      chk($sformatf("v%0d_locked", i), locked, 0);
      $display("vec %0d: ready=%b tx_data=%h grant=%0d", i, vecs[i].ready, tx_data, grant_id);
      if (vecs[i].cap) begin
        xfer();
        chk($sformatf("v%0d_tx_done", i), tx_valid, 0);
      end
    end

    // Packet lock: requester 1 sends 01,02,03 while requester 0 waits.
    req_data  = {8'hD3, 8'hC2, 8'h01, 8'hA0};
    req_last  = 4'b0000;
    req_valid = 4'b0010;
    #1;
    chk("pkt_b1_ready", req_ready, 4'b0010);
    tick();
    chk("pkt_b1_data", tx_data, 8'h01);
    chk("pkt_b1_locked", locked, 1);
    chk("pkt_b1_grant", grant_id, 1);
    req_data  = {8'hD3, 8'hC2, 8'h02, 8'hA0};
    req_last  = 4'b0001;
    req_valid = 4'b0011;
    #1;
    chk("pkt_send_ready", req_ready, 4'b0000);
    xfer();
    chk("pkt_b2_ready", req_ready, 4'b0010);
    tick();
    chk("pkt_b2_data", tx_data, 8'h02);
    chk("pkt_b2_locked", locked, 1);
    req_data = {8'hD3, 8'hC2, 8'h03, 8'hA0};
    req_last = 4'b0011;
    xfer();
    chk("pkt_b3_ready", req_ready, 4'b0010);
    tick();
    chk("pkt_b3_data", tx_data, 8'h03);
    chk("pkt_b3_locked", locked, 0);
    req_valid = 4'b0001;
    xfer();
    chk("pkt_r0_ready", req_ready, 4'b0001);
    tick();
    chk("pkt_r0_data", tx_data, 8'hA0);
    chk("pkt_r0_grant", grant_id, 0);
    $display("packet: r1 sent 01 02 03 then r0 granted, tx_data=%h", tx_data);
    req_valid = 4'b0000;
    xfer();

    // Timeout: requester 3 opens a packet then goes silent.
    req_data  = {8'hAA, 8'hC2, 8'hB1, 8'hA0};
    req_last  = 4'b0000;
    req_valid = 4'b1000;
    #1;
    chk("to_ready", req_ready, 4'b1000);
    tick();
    chk("to_locked", locked, 1);
    chk("to_grant", grant_id, 3);
    chk("to_data", tx_data, 8'hAA);
    req_valid = 4'b0000;
    xfer();
    req_last  = 4'b1111;
    req_valid = 4'b0001;
    #1;
    chk("to_lock_ready", req_ready, 4'b0000);
    n = 0;
    while (!timeout_pulse && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 20);
    chk("to_pulse", timeout_pulse, 1);
    chk("to_unlocked", locked, 0);
    chk("to_r0_ready", req_ready, 4'b0001);
    tick();
    chk("to_pulse_once", timeout_pulse, 0);
    chk("to_r0_data", tx_data, 8'hA0);
    chk("to_r0_grant", grant_id, 0);
    $display("timeout: pulse after %0d lock cycles, r0 granted", n);
    req_valid = 4'b0000;
    xfer();

    // Mask release: requester 3 locked, then masked off.
    req_data  = DATA_DEF;
    req_last  = 4'b0000;
    req_valid = 4'b1000;
    #1;
    chk("mr_ready", req_ready, 4'b1000);
    tick();
    chk("mr_locked", locked, 1);
    req_valid = 4'b0000;
    xfer();
    req_mask  = 4'b0111;
    req_valid = 4'b1000;
    #1;
    chk("mr_masked_ready", req_ready, 4'b0000);
    tick();
    chk("mr_unlocked", locked, 0);
    chk("mr_no_pulse", timeout_pulse, 0);
    req_last  = 4'b1111;
    req_valid = 4'b0100;
    #1;
    chk("mr_r2_ready", req_ready, 4'b0100);
    tick();
    chk("mr_r2_data", tx_data, 8'hC2);
    $display("mask release: r3 dropped without pulse, r2 granted");
    req_mask  = 4'b1111;
    req_valid = 4'b0000;
    xfer();

    // Reset during SEND with uart_tx not ready.
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    xfer();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    chk("rs_pre_valid", tx_valid, 1);
    chk("rs_pre_grant", grant_id, 2);
    #3;
    rst_l = 1'b0;
    #1;
    chk("rs_tx_valid", tx_valid, 0);
    chk("rs_tx_data", tx_data, 0);
    chk("rs_grant", grant_id, 0);
    chk("rs_locked", locked, 0);
    @(negedge clk);
    rst_l = 1'b1;
    tick();
    req_valid = 4'b0101;
    #1;
    chk("rs_ptr0_ready", req_ready, 4'b0001);
    tick();
    chk("rs_ptr0_data", tx_data, 8'hA0);
    $display("reset: outputs cleared, first grant from pointer 0 to r%0d", grant_id);
    req_valid = 4'b0000;
    xfer();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
